// File: rtl/game_pkg.sv
// Shared game constants for the paddle skill logic: skill indices, point ceiling,
// tick period and the small arbitration / LED helper functions.
package game_pkg;

    localparam int unsigned SKILL_J        = 32'd0;
    localparam int unsigned SKILL_K        = 32'd1;
    localparam int unsigned SKILL_L        = 32'd2;
    localparam int unsigned MAX_POINTS     = 32'd3;
    localparam int unsigned TICK_PERIOD_MS = 32'd50;

    // LED bar fills from the left as points accumulate.
    function automatic logic [2:0] points_to_led(input logic [1:0] pts);
        logic [2:0] led;
        case (pts)
            2'd0:    led = 3'b000;
            2'd1:    led = 3'b100;
            2'd2:    led = 3'b110;
            2'd3:    led = 3'b111;
            default: led = 3'b000;
        endcase
        return led;
    endfunction

    function automatic logic [2:0] pick_fixed(input logic [2:0] elig);
        logic [2:0] win;
        if (elig[0]) begin
            win = 3'b001;
        end else if (elig[1]) begin
            win = 3'b010;
        end else if (elig[2]) begin
            win = 3'b100;
        end else begin
            win = 3'b000;
        end
        return win;
    endfunction

    // Search starts one past the last winner and wraps around the three skills.
    function automatic logic [2:0] pick_rr(input logic [2:0] elig, input logic [1:0] last);
        logic [2:0] win;
        logic [1:0] idx;
        win = 3'b000;
        idx = last;
        for (int i = 0; i < 3; i++) begin
            idx = (idx == 2'd2) ? 2'd0 : (idx + 2'd1);
            if ((win == 3'b000) && elig[idx]) begin
                win = 3'b001 << idx;
            end else begin
                win = win;
            end
        end
        return win;
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
        logic [1:0] idx;
        case (oh)
            3'b010:  idx = 2'd1;
            3'b100:  idx = 2'd2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/skill_scheduler_if.sv
// Request/status bundle between the keyboard/game-state side and skill_scheduler.
interface skill_scheduler_if;
    logic       enable;
    logic [2:0] req;
    logic [2:0] active;
    logic [1:0] points;
    logic [2:0] grant;
    logic       deny;
    logic [2:0] led_bar;

    modport master (
        output enable, req,
        input  active, points, grant, deny, led_bar
    );

    modport slave (
        input  enable, req,
        output active, points, grant, deny, led_bar
    );
endinterface

// File: rtl/skill_timer.sv
// Per-skill duration timer: a load starts a DUR-tick active window, clr (game not
// running) wipes it immediately.
module skill_timer #(
    parameter int unsigned TW = 32'd7
) (
    input  logic          clk_22,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          active,
    output logic          expire
);

    logic [TW-1:0] count_r;
    logic          active_r;

    assign active = active_r;
    assign expire = active_r && (count_r == {TW{1'b0}});

    // Countdown and active flag; the last active tick is the one where count is 0.
    always_ff @(posedge clk_22 or posedge rst) begin
        if (rst) begin
            count_r  <= {TW{1'b0}};
            active_r <= 1'b0;
        end else if (clr) begin
            count_r  <= {TW{1'b0}};
            active_r <= 1'b0;
        end else if (load) begin
            count_r  <= load_val;
            active_r <= 1'b1;
        end else if (expire) begin
            active_r <= 1'b0;
        end else if (active_r) begin
            count_r  <= count_r - TW'(1);
        end else begin
            count_r  <= count_r;
        end
    end

endmodule

// File: rtl/skill_scheduler.sv
// Skill point budget, regeneration and arbitration for the J/K/L paddle skills.
// Define SKILL_SCHED_RR_EN for round-robin arbitration; default is fixed priority J > K > L.
module skill_scheduler #(
    parameter int unsigned MAX_POINTS  = game_pkg::MAX_POINTS,
    parameter int unsigned REGEN_TICKS = 32'd200,
    parameter int unsigned DUR_J       = 32'd100,
    parameter int unsigned DUR_K       = 32'd100,
    parameter int unsigned DUR_L       = 32'd60
) (
    input logic              clk_22,
    input logic              rst,
    skill_scheduler_if.slave bus
);
    import game_pkg::*;

    localparam int unsigned DUR_JK  = (DUR_J > DUR_K) ? DUR_J : DUR_K;
    localparam int unsigned DUR_MAX = (DUR_JK > DUR_L) ? DUR_JK : DUR_L;
    localparam int unsigned TW      = (DUR_MAX > 32'd1) ? $clog2(DUR_MAX) : 32'd1;
    localparam int unsigned RW      = (REGEN_TICKS > 32'd1) ? $clog2(REGEN_TICKS) : 32'd1;

    localparam logic [TW-1:0] LOAD_J     = TW'(DUR_J - 32'd1);
    localparam logic [TW-1:0] LOAD_K     = TW'(DUR_K - 32'd1);
    localparam logic [TW-1:0] LOAD_L     = TW'(DUR_L - 32'd1);
    localparam logic [RW-1:0] REGEN_LAST = RW'(REGEN_TICKS - 32'd1);
    localparam logic [1:0]    PTS_MAX    = 2'(MAX_POINTS);

    logic [2:0]    active_s;
    logic [2:0]    expire_unused_s;
    logic [2:0]    eligible_s;
    logic [2:0]    grant_s;
    logic          deny_s;
    logic          clr_s;
    logic          regen_wrap_s;
    logic [RW-1:0] regen_nxt_s;
    logic [1:0]    points_dec_s;
    logic [1:0]    points_nxt_s;

    logic [RW-1:0] regen_r;
    logic [1:0]    points_r;
    logic [2:0]    grant_r;
    logic          deny_r;
    logic [2:0]    led_r;

`ifdef SKILL_SCHED_RR_EN
    logic [1:0]    last_r;
`endif

    assign clr_s = ~bus.enable;

    skill_timer #(.TW(TW)) u_timer_j (
        .clk_22(clk_22), .rst(rst), .clr(clr_s), .load(grant_s[SKILL_J]), .load_val(LOAD_J),
        .active(active_s[SKILL_J]), .expire(expire_unused_s[SKILL_J])
    );
    skill_timer #(.TW(TW)) u_timer_k (
        .clk_22(clk_22), .rst(rst), .clr(clr_s), .load(grant_s[SKILL_K]), .load_val(LOAD_K),
        .active(active_s[SKILL_K]), .expire(expire_unused_s[SKILL_K])
    );
    skill_timer #(.TW(TW)) u_timer_l (
        .clk_22(clk_22), .rst(rst), .clr(clr_s), .load(grant_s[SKILL_L]), .load_val(LOAD_L),
        .active(active_s[SKILL_L]), .expire(expire_unused_s[SKILL_L])
    );

    // Arbitration, deny, regen counter and point budget next-state.
    always_comb begin
        eligible_s   = bus.req & ~active_s;
        grant_s      = 3'b000;
        deny_s       = 1'b0;
        regen_wrap_s = 1'b0;
        regen_nxt_s  = {RW{1'b0}};

        if (bus.enable && (eligible_s != 3'b000)) begin
            if (points_r != 2'd0) begin
`ifdef SKILL_SCHED_RR_EN
                grant_s = pick_rr(eligible_s, last_r);
`else
                grant_s = pick_fixed(eligible_s);
`endif
            end else begin
                deny_s = 1'b1;
            end
        end else begin
            grant_s = 3'b000;
        end

        if (!bus.enable) begin
            regen_nxt_s = {RW{1'b0}};
        end else if (regen_r == REGEN_LAST) begin
            regen_wrap_s = 1'b1;
            regen_nxt_s  = {RW{1'b0}};
        end else begin
            regen_nxt_s = regen_r + RW'(1);
        end

        // Spend first, then regenerate with saturation so 3 - 1 + 1 stays 3.
        points_dec_s = (grant_s != 3'b000) ? (points_r - 2'd1) : points_r;
        if (!bus.enable) begin
            points_nxt_s = 2'd0;
        end else if (regen_wrap_s) begin
            points_nxt_s = (points_dec_s >= PTS_MAX) ? PTS_MAX : (points_dec_s + 2'd1);
        end else begin
            points_nxt_s = points_dec_s;
        end
    end

    // Registered budget, regen counter and one-tick grant/deny pulses.
    always_ff @(posedge clk_22 or posedge rst) begin
        if (rst) begin
            regen_r  <= {RW{1'b0}};
            points_r <= 2'd0;
            grant_r  <= 3'b000;
            deny_r   <= 1'b0;
            led_r    <= 3'b000;
        end else begin
            regen_r  <= regen_nxt_s;
            points_r <= points_nxt_s;
            grant_r  <= grant_s;
            deny_r   <= deny_s;
            led_r    <= points_to_led(points_nxt_s);
        end
    end

`ifdef SKILL_SCHED_RR_EN
    // Last winner; reset to L so J is first in line.
    always_ff @(posedge clk_22 or posedge rst) begin
        if (rst) begin
            last_r <= 2'd2;
        end else if (grant_s != 3'b000) begin
            last_r <= onehot_to_idx(grant_s);
        end else begin
            last_r <= last_r;
        end
    end
`endif

    assign bus.active  = active_s;
    assign bus.points  = points_r;
    assign bus.grant   = grant_r;
    assign bus.deny    = deny_r;
    assign bus.led_bar = led_r;

endmodule
